// File: rtl/dda_interp_multi.sv
// Multi-axis DDA step generator: lock-step Bresenham-style pulse distribution over N ticks.
// Optional macro DDA_LS_ABORT_EN: a limit switch on a moving axis aborts the move and sets fault.
module dda_interp_multi #(
  parameter int NAXES = 3,
  parameter int WIDTH = 16,
  parameter int PW    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [NAXES*(WIDTH+1)-1:0]   nx,
  input  logic [WIDTH-1:0]             n_total,
  input  logic [15:0]                  tick_div,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NAXES-1:0]             ls,
  output logic [NAXES-1:0]             pulse,
  output logic [NAXES-1:0]             dir,
  output logic                         busy,
  output logic                         done,
  output logic                         fault,
  output logic [1:0]                   dbg_state
);

  localparam int PCW = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADED = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_mag    [NAXES];
  logic [WIDTH:0]   r_acc    [NAXES];
  logic [PCW-1:0]   r_pw_cnt [NAXES];
  logic [WIDTH-1:0] r_n;
  logic [15:0]      r_div;
  logic [WIDTH-1:0] r_iter;
  logic [15:0]      r_tick;

  logic             w_load_ok;
  logic             w_iter;
  logic             w_last;
  logic             w_ls_hit;
  logic             w_stop;
  logic [NAXES-1:0] w_fire;
  logic [WIDTH:0]   w_acc_next [NAXES];

  assign dbg_state = r_state;

  always_comb begin
    w_load_ok = (n_total != '0) && (tick_div > 16'(PW));
    for (int i = 0; i < NAXES; i++) begin
      if (nx[i*(WIDTH+1) +: WIDTH] > n_total) w_load_ok = 1'b0;
    end
  end

  assign w_iter = (r_state == S_RUN) && (r_tick == r_div - 16'd1);
  assign w_last = w_iter && (r_iter == r_n - WIDTH'(1));

  // acc < N and mag <= N, so the sum stays below 2N and fits in WIDTH+1 bits.
  always_comb begin
    for (int i = 0; i < NAXES; i++) begin
      w_acc_next[i] = r_acc[i] + {1'b0, r_mag[i]};
      w_fire[i]     = (w_acc_next[i] >= {1'b0, r_n});
      if (w_fire[i]) w_acc_next[i] = w_acc_next[i] - {1'b0, r_n};
    end
  end

`ifdef DDA_LS_ABORT_EN
  logic [NAXES-1:0] w_mag_nz;
  always_comb begin
    for (int i = 0; i < NAXES; i++) w_mag_nz[i] = (r_mag[i] != '0);
  end
  assign w_ls_hit = w_iter && |(ls & w_mag_nz);
`else
  assign w_ls_hit = 1'b0;
`endif

  assign w_stop = (r_state == S_RUN) && (abort || w_ls_hit);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A load beats a coincident start; abort beats a coincident final iteration.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_LOADED: begin
        if (load)                                w_next = w_load_ok ? S_LOADED : S_IDLE;
        else if (start && r_state == S_LOADED)   w_next = S_RUN;
      end
      S_RUN: begin
        if (w_stop || w_last) w_next = S_LOADED;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse  <= '0;
      dir    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      fault  <= 1'b0;
      r_n    <= '0;
      r_div  <= '0;
      r_iter <= '0;
      r_tick <= '0;
      for (int i = 0; i < NAXES; i++) begin
        r_mag[i]    <= '0;
        r_acc[i]    <= '0;
        r_pw_cnt[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      busy <= (w_next == S_RUN);
      for (int i = 0; i < NAXES; i++) begin
        if (r_pw_cnt[i] != '0) r_pw_cnt[i] <= r_pw_cnt[i] - PCW'(1);
        else                   pulse[i]    <= 1'b0;
      end

      if (load && r_state != S_RUN) begin
        if (w_load_ok) begin
          r_n   <= n_total;
          r_div <= tick_div;
          fault <= 1'b0;
          for (int i = 0; i < NAXES; i++) begin
            r_mag[i] <= nx[i*(WIDTH+1) +: WIDTH];
            dir[i]   <= nx[i*(WIDTH+1) + WIDTH];
          end
        end else begin
          r_n   <= '0;
          r_div <= '0;
          fault <= 1'b1;
          for (int i = 0; i < NAXES; i++) r_mag[i] <= '0;
        end
      end else if (start && r_state == S_LOADED) begin
        r_iter <= '0;
        r_tick <= '0;
        for (int i = 0; i < NAXES; i++) r_acc[i] <= '0;
      end

      if (r_state == S_RUN) begin
        if (w_stop) begin
          pulse <= '0;
          for (int i = 0; i < NAXES; i++) r_pw_cnt[i] <= '0;
          if (w_ls_hit) fault <= 1'b1;
        end else begin
          r_tick <= w_iter ? 16'd0 : r_tick + 16'd1;
          if (w_iter) begin
            r_iter <= r_iter + WIDTH'(1);
            if (w_last) done <= 1'b1;
            // A limit switch only masks the output; the accumulator keeps its count.
            for (int i = 0; i < NAXES; i++) begin
              r_acc[i] <= w_acc_next[i];
              if (w_fire[i] && !ls[i]) begin
                pulse[i]    <= 1'b1;
                r_pw_cnt[i] <= PCW'(PW - 1);
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dda_interp_multi.sv
// Directed bench for dda_interp_multi (NAXES=3, WIDTH=8, PW=2); hand-computed pulse counts and timing.
module tb_dda_interp_multi;

  localparam int NAXES = 3;
  localparam int WIDTH = 8;
  localparam int PW    = 2;
  localparam int NXW   = NAXES * (WIDTH + 1);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [NXW-1:0]   nx = '0;
  logic [WIDTH-1:0] n_total = '0;
  logic [15:0]      tick_div = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [NAXES-1:0] ls = '0;
  logic [NAXES-1:0] pulse;
  logic [NAXES-1:0] dir;
  logic             busy;
  logic             done;
  logic             fault;
  logic [1:0]       dbg_state;

  dda_interp_multi #(.NAXES(NAXES), .WIDTH(WIDTH), .PW(PW)) dut (
    .clk(clk), .rst(rst), .load(load), .nx(nx), .n_total(n_total),
    .tick_div(tick_div), .start(start), .abort(abort), .ls(ls),
    .pulse(pulse), .dir(dir), .busy(busy), .done(done), .fault(fault),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor, sampled on the falling edge
  int rises [NAXES] = '{default: 0};
  int highs [NAXES] = '{default: 0};
  int ax1_rise [3]  = '{default: 0};
  int done_cnt = 0;
  int done_cyc = 0;
  int done_busy_cnt = 0;
  logic [NAXES-1:0] prev = '0;

  always @(negedge clk) begin
    for (int i = 0; i < NAXES; i++) begin
      if (pulse[i]) highs[i] <= highs[i] + 1;
      if (pulse[i] && !prev[i]) rises[i] <= rises[i] + 1;
    end
    if (pulse[1] && !prev[1]) begin
      ax1_rise[0] <= ax1_rise[1];
      ax1_rise[1] <= ax1_rise[2];
      ax1_rise[2] <= cyc;
    end
    prev <= pulse;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (busy) done_busy_cnt <= done_busy_cnt + 1;
    end
  end

  int b_r [NAXES];
  int b_h0, b_d, b_db;
  int t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_load(input logic [NXW-1:0] v_nx, input logic [WIDTH-1:0] v_n,
                         input logic [15:0] v_div);
    @(negedge clk);
    nx = v_nx; n_total = v_n; tick_div = v_div; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start(output int t_start);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic snap();
    @(negedge clk);
    for (int i = 0; i < NAXES; i++) b_r[i] = rises[i];
    b_h0 = highs[0];
    b_d  = done_cnt;
    b_db = done_busy_cnt;
  endtask

  // axis0 = +10, axis1 = -3, axis2 = 0
  localparam logic [NXW-1:0] NX_BASIC = {1'b0, 8'd0, 1'b1, 8'd3, 1'b0, 8'd10};
  localparam logic [NXW-1:0] NX_BAD   = {1'b0, 8'd0, 1'b1, 8'd3, 1'b0, 8'd11};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pulse", pulse, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;

    // basic move
    do_load(NX_BASIC, 8'd10, 16'd4);
    chk("load_dir", dir, 3'b010);
    chk("load_fault", fault, 0);
    chk("load_state", dbg_state, 1);
    snap();
    do_start(t0);
    chk("start_busy", busy, 1);
    wait_cyc(t0 + 46);
    chk("basic_ax0", rises[0] - b_r[0], 10);
    chk("basic_ax1", rises[1] - b_r[1], 3);
    chk("basic_ax2", rises[2] - b_r[2], 0);
    chk("basic_ax0_width", highs[0] - b_h0, 20);
    chk("basic_ax1_it4", ax1_rise[0] - t0, 16);
    chk("basic_ax1_it7", ax1_rise[1] - t0, 28);
    chk("basic_ax1_it10", ax1_rise[2] - t0, 40);
    chk("basic_done_cnt", done_cnt - b_d, 1);
    chk("basic_done_time", done_cyc - t0, 40);
    chk("basic_done_busy", done_busy_cnt - b_db, 0);
    chk("basic_end_state", dbg_state, 1);
    chk("basic_end_busy", busy, 0);

    // invalid load, then start ignored, then valid load clears fault
    do_load(NX_BAD, 8'd10, 16'd4);
    chk("bad_fault", fault, 1);
    chk("bad_state", dbg_state, 0);
    do_start(t0);
    chk("bad_start_busy", busy, 0);
    wait_cyc(t0 + 3);
    chk("bad_start_busy2", busy, 0);
    chk("bad_start_state", dbg_state, 0);
    do_load(NX_BASIC, 8'd10, 16'd4);
    chk("reload_fault", fault, 0);
    chk("reload_state", dbg_state, 1);

`ifdef DDA_LS_ABORT_EN
    // limit switch on axis1 before iteration 4 aborts the move
    snap();
    do_start(t0);
    wait_cyc(t0 + 14);
    ls = 3'b010;
    wait_cyc(t0 + 16);
    chk("lsab_busy", busy, 0);
    chk("lsab_fault", fault, 1);
    chk("lsab_pulse", pulse, 0);
    ls = 3'b000;
    wait_cyc(t0 + 46);
    chk("lsab_ax0", rises[0] - b_r[0], 3);
    chk("lsab_ax1", rises[1] - b_r[1], 0);
    chk("lsab_done", done_cnt - b_d, 0);
    chk("lsab_state", dbg_state, 1);
    do_load(NX_BASIC, 8'd10, 16'd4);
    chk("lsab_reload_fault", fault, 0);
`else
    // limit switch on axis0 masks iterations 3..5
    snap();
    do_start(t0);
    wait_cyc(t0 + 10);
    ls = 3'b001;
    wait_cyc(t0 + 21);
    ls = 3'b000;
    wait_cyc(t0 + 46);
    chk("mask_ax0", rises[0] - b_r[0], 7);
    chk("mask_ax1", rises[1] - b_r[1], 3);
    chk("mask_done_cnt", done_cnt - b_d, 1);
    chk("mask_done_time", done_cyc - t0, 40);
    chk("mask_fault", fault, 0);
`endif

    // abort mid-move truncates the iteration-3 pulse
    snap();
    do_start(t0);
    wait_cyc(t0 + 12);
    abort = 1'b1;
    wait_cyc(t0 + 13);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pulse", pulse, 0);
    chk("abort_state", dbg_state, 1);
    wait_cyc(t0 + 46);
    chk("abort_done", done_cnt - b_d, 0);
    chk("abort_ax0", rises[0] - b_r[0], 3);
    chk("abort_ax0_width", highs[0] - b_h0, 5);

    // replay from retained values
    snap();
    do_start(t0);
    wait_cyc(t0 + 46);
    chk("replay_ax0", rises[0] - b_r[0], 10);
    chk("replay_ax1", rises[1] - b_r[1], 3);
    chk("replay_ax2", rises[2] - b_r[2], 0);
    chk("replay_done", done_cnt - b_d, 1);

    // reset mid-run clears everything; start without load is ignored
    do_start(t0);
    wait_cyc(t0 + 19);
    rst = 1'b1;
    wait_cyc(t0 + 20);
    chk("mrst_pulse", pulse, 0);
    chk("mrst_dir", dir, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_fault", fault, 0);
    chk("mrst_state", dbg_state, 0);
    rst = 1'b0;
    do_start(t0);
    wait_cyc(t0 + 3);
    chk("mrst_start_busy", busy, 0);
    chk("mrst_start_state", dbg_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dda_interp_multi.md
# dda_interp_multi

Parametrised multi-axis DDA (digital differential analyser) step generator: the next generation of the team's single-axis DDA pulse block. It accepts a signed step count per axis and a common iteration count N, then emits evenly distributed step pulses and direction levels for all axes in lock-step over N iteration ticks. It sits between the motion command register interface and the stepper driver pins. Compared with the single-axis block it adds an explicit load/start/abort handshake, exact pulse counts, a programmable tick rate, and limit-switch handling.

## Interface
- `NAXES`, 3, number of axes.
- `WIDTH`, 16, magnitude width of per-axis step counts and N.
- `PW`, 2, step pulse high width in clk cycles.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `load`  input  1  one-cycle strobe; latches `nx`, `n_total`, `tick_div`.
- `nx`  input  NAXES*(WIDTH+1)  per axis i, bits [i*(WIDTH+1) +: WIDTH+1]: MSB = direction, low WIDTH bits = step magnitude.
- `n_total`  input  WIDTH  iteration count N.
- `tick_div`  input  16  clk cycles per iteration tick.
- `start`  input  1  one-cycle strobe; begins motion from LOADED.
- `abort`  input  1  stops motion immediately.
- `ls`  input  NAXES  per-axis limit switch, active high.
- `pulse`  output  NAXES  step pulses, registered.
- `dir`  output  NAXES  direction levels, registered.
- `busy`  output  1  high in RUN.
- `done`  output  1  one-cycle completion strobe.
- `fault`  output  1  sticky error flag.

## Operation
- States: IDLE, LOADED, RUN.
- IDLE/LOADED + `load`: the load is valid if N != 0, `tick_div` > PW, and every magnitude <= N. If valid, latch all inputs, update `dir` from the sign bits, clear `fault`, and go to LOADED. If invalid, set `fault` and go to IDLE; prior latched values are discarded.
- `load` in RUN is ignored.
- LOADED + `start`: clear the accumulators, iteration counter and tick counter, then go to RUN. `start` in IDLE or RUN is ignored.
- RUN, each iteration (tick counter reaches `tick_div`-1, then wraps to 0):
  - for each axis, acc_i += mag_i;
  - if acc_i >= N then acc_i -= N and fire axis i;
  - the iteration counter increments.
- Accumulators are WIDTH+1 bits and never overflow because acc < 2N.
- With magnitude <= N and acc starting at 0, each axis fires exactly mag_i times over N iterations.
- A fired axis drives `pulse[i]` high for PW cycles, unless it is masked by `ls[i]`.
- After iteration N: assert `done` for 1 cycle, return to LOADED (latched values retained, so `start` replays the move), and drop `busy`.
- `abort` in RUN: go to LOADED, force `pulse` to 0 the next cycle, no `done`. `abort` has priority over a coincident iteration.
- `ls[i]` high, default build: suppress `pulse[i]` output only. The accumulator and the count continue, so the pulses for that iteration are lost.
- `rst`: state IDLE; `pulse`, `dir`, `busy`, `done`, `fault` all 0; accumulators and counters 0; latched values cleared.
- Simultaneous `load` and `start` in LOADED: `load` wins and `start` is dropped.

## Timing
- Registers update one cycle after the input. If `load` is sampled at edge t, `dir`/`fault` are valid from t+1.
- If `start` is sampled at edge t0:
  - `busy` is high from t0+1.
  - Iteration k (1..N) is evaluated at edge t0+k*`tick_div`.
  - The fired `pulse` is high for cycles t0+k*`tick_div`+1 through +PW.
- `dir` is stable for at least `tick_div` cycles before the first pulse.
- `done` is high for the single cycle t0+N*`tick_div`+1, and `busy` is low in that same cycle.
- `abort` sampled at t: `busy`=0 and `pulse`=0 from t+1. A pulse in progress is truncated.
- `ls` is sampled at the iteration edge only; the pulse width is not re-checked mid-pulse.

## Configuration
- `DDA_LS_ABORT_EN` defined: `ls[i]` high at any iteration edge in RUN, for an axis with mag_i != 0, aborts the move as `abort` does and additionally sets `fault`. No pulse is issued for that iteration on any axis.
- `DDA_LS_ABORT_EN` undefined: masking-only behaviour as in Operation; `ls` never sets `fault`.

## Test plan
- Basic move. NAXES=3, WIDTH=8, PW=2, N=10, `tick_div`=4, nx = {+10, -3, 0}. Load, then start at t0.
  - Axis0: 10 pulses.
  - Axis1: 3 pulses at iterations 4, 7, 10 (edges t0+16/28/40), with `dir[1]`=1.
  - Axis2: no pulses.
  - `done` at t0+41.
- Invalid load. Magnitude 11 with N=10 -> `fault`=1, state IDLE, a following `start` gives no `busy`. A valid load then clears `fault`.
- Limit masking, macro off. Same move as the basic test, with `ls[0]` high during iterations 3-5 -> axis0 gives 7 pulses. Axis1 is unchanged; `done` is on time.
- Abort. `abort` at t0+13 -> `busy`=0 and `pulse`=0 at t0+14, no `done`. A re-`start` replays the full move (10/3/0 pulses).
- Mid-run reset. `rst` at t0+20 -> all outputs 0 the next cycle. A later `start` without `load` is ignored.
- Limit abort, macro on. `ls[1]` is asserted before iteration 4 -> no pulse at iteration 4, `busy` drops, `fault`=1, no `done`.
